// File: rtl/hps_reset_req_gen.sv
// hps_reset_req_gen: fabric-side front end for the HPS reset-request inputs
// and the STM hardware-event bus. Raw push-buttons and slide switches are
// synchronized and debounced. Key presses become prioritized, fixed-width,
// active-low cold/warm/debug reset-request pulses. Debounced state and press
// events are packed onto the 28-bit event bus.
module hps_reset_req_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [2:0]  key_n,
    input  logic [3:0]  sw,
    input  logic        hps_0_h2f_reset_reset_n,
    output logic        hps_0_f2h_cold_reset_req_reset_n,
    output logic        hps_0_f2h_warm_reset_req_reset_n,
    output logic        hps_0_f2h_debug_reset_req_reset_n,
    output logic [27:0] hps_0_f2h_stm_hw_events_stm_hwevents,
    output logic        req_busy
);

    // Debounce counter sizing: the counter never needs to exceed DEBOUNCE_CYCLES-1.
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCW-1:0] DEB_MAX  = {DCW{1'b1}};

    // Pulse counter counts down from PULSE_CYCLES-1 to 0.
    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [2:0]     r_key_meta;
    logic [2:0]     r_key_sync;
    logic [3:0]     r_sw_meta;
    logic [3:0]     r_sw_sync;
    logic [6:0]     w_sync_level;
    logic [6:0]     r_db;
    logic [DCW-1:0] r_db_cnt [7];
    logic [2:0]     r_pressed_q;
    logic [2:0]     r_press_evt;

    state_t         r_state;
    state_t         w_state_next;
    logic [PCW-1:0] r_pulse_cnt;
    logic [PCW-1:0] w_pulse_cnt_next;
    logic [1:0]     r_sel;
    logic [1:0]     w_sel_next;
    logic [2:0]     w_req_n_next;
    logic [2:0]     r_req_n;
    logic           r_busy;

    // Two-flop synchronizers; keys idle high (released), switches idle low.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_key_meta <= 3'b111;
            r_key_sync <= 3'b111;
            r_sw_meta  <= 4'b0000;
            r_sw_sync  <= 4'b0000;
        end else begin
            r_key_meta <= key_n;
            r_key_sync <= r_key_meta;
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // Keys are flipped to active-high "pressed" so all seven inputs debounce alike.
    assign w_sync_level = {r_sw_sync, ~r_key_sync};

    // Per-input debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_db <= 7'b0000000;
            for (int i = 0; i < 7; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (w_sync_level[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DEB_LAST) begin
                    r_db[i]     <= w_sync_level[i];
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] != DEB_MAX) begin
                    r_db_cnt[i] <= r_db_cnt[i] + DCW'(1);
                end
            end
        end
    end

    // One-cycle press event on each rising edge of a debounced key; releases are ignored.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_pressed_q <= 3'b000;
            r_press_evt <= 3'b000;
        end else begin
            r_pressed_q <= r_db[2:0];
            r_press_evt <= r_db[2:0] & ~r_pressed_q;
        end
    end

    // Request FSM next state: pick one press (cold > warm > debug), pulse, then wait for quiet.
    always_comb begin
        w_state_next     = r_state;
        w_pulse_cnt_next = r_pulse_cnt;
        w_sel_next       = r_sel;
        w_req_n_next     = 3'b111;
        case (r_state)
            ST_IDLE: begin
                if (hps_0_h2f_reset_reset_n && (r_press_evt != 3'b000)) begin
                    w_state_next     = ST_PULSE;
                    w_pulse_cnt_next = PULSE_LOAD;
                    if (r_press_evt[0]) begin
                        w_sel_next = 2'd0;
                    end else if (r_press_evt[1]) begin
                        w_sel_next = 2'd1;
                    end else begin
                        w_sel_next = 2'd2;
                    end
                end
            end
            ST_PULSE: begin
                if (r_pulse_cnt == '0) begin
                    w_state_next = ST_HOLDOFF;
                end else begin
                    w_pulse_cnt_next = r_pulse_cnt - PCW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (hps_0_h2f_reset_reset_n && (r_db[2:0] == 3'b000)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_state_next == ST_PULSE) begin
            case (w_sel_next)
                2'd0:    w_req_n_next = 3'b110;
                2'd1:    w_req_n_next = 3'b101;
                default: w_req_n_next = 3'b011;
            endcase
        end
    end

    // FSM state register; request and busy outputs are registered from the next state.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state     <= ST_IDLE;
            r_pulse_cnt <= '0;
            r_sel       <= 2'd0;
            r_req_n     <= 3'b111;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_sel       <= w_sel_next;
            r_req_n     <= w_req_n_next;
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    assign hps_0_f2h_cold_reset_req_reset_n     = r_req_n[0];
    assign hps_0_f2h_warm_reset_req_reset_n     = r_req_n[1];
    assign hps_0_f2h_debug_reset_req_reset_n    = r_req_n[2];
    assign req_busy                             = r_busy;
    assign hps_0_f2h_stm_hw_events_stm_hwevents = {18'd0, r_press_evt, r_db};

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// tb_hps_reset_req_gen: directed walk through reset, bounce, requests, priority,
// HPS gating, switches and mid-pulse reset, followed by a randomized phase. Every
// edge is checked against a behavioural model built from the block's rules.
module tb_hps_reset_req_gen;

    localparam int DEB = 4;
    localparam int PUL = 3;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [2:0]  key_n;
    logic [3:0]  sw;
    logic        hps_0_h2f_reset_reset_n;
    logic        coldN;
    logic        warmN;
    logic        debugN;
    logic [27:0] stmBus;
    logic        reqBusy;

    int compared   = 0;
    int mismatched = 0;

    // Model state, all in active-high "pressed" space: {sw, ~key_n}
    logic [6:0] mMeta;
    logic [6:0] mSync;
    logic [6:0] mDeb;
    logic [6:0] mHist [DEB];
    logic [2:0] mPrev;
    logic [2:0] mEvt;
    int         mPulseLeft;
    int         mReqIdx;
    bit         mHoldoff;

    hps_reset_req_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_CYCLES(PUL)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .key_n(key_n),
        .sw(sw),
        .hps_0_h2f_reset_reset_n(hps_0_h2f_reset_reset_n),
        .hps_0_f2h_cold_reset_req_reset_n(coldN),
        .hps_0_f2h_warm_reset_req_reset_n(warmN),
        .hps_0_f2h_debug_reset_req_reset_n(debugN),
        .hps_0_f2h_stm_hw_events_stm_hwevents(stmBus),
        .req_busy(reqBusy)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_clk = ~clk_clk;

    task automatic applyStimulus(input logic rstN, input logic [2:0] keys,
                                 input logic [3:0] sws, input logic h2f);
        reset_reset_n           = rstN;
        key_n                   = keys;
        sw                      = sws;
        hps_0_h2f_reset_reset_n = h2f;
    endtask

    // Advance the model across one clock edge using the inputs present before it
    task automatic modelEdge();
        logic [6:0] raw;
        logic [6:0] newDeb;
        logic [2:0] newEvt;
        bit         allDiffer;
        raw = {sw, ~key_n};
        if (!reset_reset_n) begin
            mMeta      = '0;
            mSync      = '0;
            mDeb       = '0;
            mPrev      = '0;
            mEvt       = '0;
            mPulseLeft = 0;
            mReqIdx    = 0;
            mHoldoff   = 0;
            for (int k = 0; k < DEB; k++) mHist[k] = '0;
        end else begin
            // Requests: a pulse of PUL cycles, then hold off until HPS is up and keys released
            if (mPulseLeft > 0) begin
                mPulseLeft = mPulseLeft - 1;
                if (mPulseLeft == 0) mHoldoff = 1;
            end else if (mHoldoff) begin
                if (hps_0_h2f_reset_reset_n && mDeb[2:0] == 3'b000) mHoldoff = 0;
            end else if (hps_0_h2f_reset_reset_n && mEvt != 3'b000) begin
                mReqIdx    = mEvt[0] ? 0 : (mEvt[1] ? 1 : 2);
                mPulseLeft = PUL;
            end
            // Press event: debounced key was released last cycle, pressed now
            newEvt = mDeb[2:0] & ~mPrev;
            mPrev  = mDeb[2:0];
            mEvt   = newEvt;
            // Debounced level flips once the last DEB synchronized samples all disagree with it
            newDeb = mDeb;
            for (int i = 0; i < 7; i++) begin
                allDiffer = 1;
                for (int k = 0; k < DEB; k++) begin
                    if (mHist[k][i] == mDeb[i]) allDiffer = 0;
                end
                if (allDiffer) newDeb[i] = ~mDeb[i];
            end
            mDeb  = newDeb;
            mSync = mMeta;
            mMeta = raw;
            for (int k = 0; k < DEB - 1; k++) mHist[k] = mHist[k + 1];
            mHist[DEB - 1] = mSync;
        end
    endtask

    task automatic checkOne(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%07h expected=0x%07h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [2:0] expReqN;
        expReqN = 3'b111;
        if (mPulseLeft > 0) expReqN[mReqIdx] = 1'b0;
        checkOne("cold_req_n",  {27'd0, coldN},   {27'd0, expReqN[0]});
        checkOne("warm_req_n",  {27'd0, warmN},   {27'd0, expReqN[1]});
        checkOne("debug_req_n", {27'd0, debugN},  {27'd0, expReqN[2]});
        checkOne("stm_bus",     stmBus,           {18'd0, mEvt, mDeb});
        checkOne("req_busy",    {27'd0, reqBusy}, {27'd0, (mPulseLeft > 0 || mHoldoff)});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            modelEdge();
            #1;
            checkOutput();
        end
    endtask

    // Tick n cycles and count request-low cycles plus cycles where bus bits 8 and 9 are both set
    task automatic tickCount(input int n, output int coldLows, output int warmLows,
                             output int debugLows, output int evtBoth);
        coldLows = 0; warmLows = 0; debugLows = 0; evtBoth = 0;
        repeat (n) begin
            tick(1);
            if (coldN === 1'b0)  coldLows++;
            if (warmN === 1'b0)  warmLows++;
            if (debugN === 1'b0) debugLows++;
            if (stmBus[8] === 1'b1 && stmBus[9] === 1'b1) evtBoth++;
        end
    endtask

    // Tick until the selected request goes low, giving up after budget cycles
    task automatic waitLow(input int idx, input int budget, output bit found);
        logic [2:0] reqs;
        found = 0;
        for (int k = 0; k < budget && !found; k++) begin
            tick(1);
            reqs = {debugN, warmN, coldN};
            if (reqs[idx] === 1'b0) found = 1;
        end
    endtask

    initial begin
        int  cl, wl, dl, both;
        bit  found;
        logic [2:0] keys;
        logic [3:0] sws;
        logic       h2f;
        logic       rst;

        // Reset values with arbitrary inputs
        applyStimulus(1'b0, 3'($urandom), 4'($urandom), 1'($urandom));
        tick(5);
        checkOne("reset_bus",  stmBus, 28'h0);
        checkOne("reset_cold", {27'd0, coldN}, 28'd1);
        checkOne("reset_busy", {27'd0, reqBusy}, 28'd0);

        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tick(6);

        // Bounce rejection on the cold key
        applyStimulus(1'b1, 3'b110, 4'b0000, 1'b1); tick(3);
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1); tick(2);
        applyStimulus(1'b1, 3'b110, 4'b0000, 1'b1); tick(2);
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tickCount(10, cl, wl, dl, both);
        checkOne("bounce_cold_lows", 28'(cl), 28'd0);
        checkOne("bounce_bus", stmBus, 28'h0);

        // Clean cold request, release, second request
        applyStimulus(1'b1, 3'b110, 4'b0000, 1'b1);
        tickCount(12 + $urandom_range(0, 6), cl, wl, dl, both);
        checkOne("cold_width", 28'(cl), 28'(PUL));
        checkOne("cold_busy_held", {27'd0, reqBusy}, 28'd1);
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tick(10);
        checkOne("cold_busy_released", {27'd0, reqBusy}, 28'd0);
        applyStimulus(1'b1, 3'b110, 4'b0000, 1'b1);
        tickCount(14, cl, wl, dl, both);
        checkOne("cold_second_width", 28'(cl), 28'(PUL));
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tick(10);

        // Priority: warm and debug pressed together
        applyStimulus(1'b1, 3'b001, 4'b0000, 1'b1);
        tickCount(14, cl, wl, dl, both);
        checkOne("prio_warm_width", 28'(wl), 28'(PUL));
        checkOne("prio_debug_lows", 28'(dl), 28'd0);
        checkOne("prio_evt_both",   28'(both), 28'd1);
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tick(10);

        // HPS in reset: press is discarded
        applyStimulus(1'b1, 3'b110, 4'b0000, 1'b0);
        tickCount(14, cl, wl, dl, both);
        checkOne("gated_cold_lows", 28'(cl), 28'd0);
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b0);
        tick(10);
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tick(2);

        // HPS drops into reset during a warm pulse
        applyStimulus(1'b1, 3'b101, 4'b0000, 1'b1);
        waitLow(1, 20, found);
        checkOne("warm_start_found", {27'd0, found}, 28'd1);
        applyStimulus(1'b1, 3'b101, 4'b0000, 1'b0);
        tickCount(8, cl, wl, dl, both);
        checkOne("warm_rest_width", 28'(wl), 28'(PUL - 1));
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b0);
        tick(10);
        checkOne("holdoff_busy", {27'd0, reqBusy}, 28'd1);
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tick(3);
        checkOne("holdoff_exit_busy", {27'd0, reqBusy}, 28'd0);

        // Switches onto the bus
        applyStimulus(1'b1, 3'b111, 4'b1010, 1'b1);
        tick(7);
        checkOne("sw_bus", {24'd0, stmBus[6:3]}, 28'hA);

        // Reset in the second cycle of a cold pulse, key held across reset
        applyStimulus(1'b1, 3'b110, 4'b1010, 1'b1);
        waitLow(0, 20, found);
        checkOne("cold_start_found", {27'd0, found}, 28'd1);
        tick(1);
        applyStimulus(1'b0, 3'b110, 4'b1010, 1'b1);
        tick(1);
        checkOne("midpulse_reset_cold", {27'd0, coldN}, 28'd1);
        checkOne("midpulse_reset_bus",  stmBus, 28'h0);
        tick(2);
        applyStimulus(1'b1, 3'b110, 4'b1010, 1'b1);
        tickCount(14, cl, wl, dl, both);
        checkOne("post_reset_cold_width", 28'(cl), 28'(PUL));
        applyStimulus(1'b1, 3'b111, 4'b0000, 1'b1);
        tick(10);

        // Randomized phase: key chatter and holds, switch changes, HPS drops, rare resets
        keys = 3'b111; sws = 4'b0000; h2f = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) keys[$urandom_range(0, 2)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) sws = 4'($urandom);
            if ($urandom_range(0, 39) == 0) h2f = ~h2f;
            rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            applyStimulus(rst, keys, sws, h2f);
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
